training_sample_feeder: RTL and testbench
=========================================

// Module: training_sample_feeder
// PURPOSE
//  Upstream stage of the perceptron training datapath. Holds a buffer of training
//  samples (x1, x2, target t) and presents them one at a time on x1Data/x2Data/tData.
//  Sequences epochs and records whether any weight update occurred in each epoch.
//  Reports convergence (a clean epoch) or timeout (epoch limit reached) to the
//  training controller.
// PARAMETERS
//  DEPTH      16   sample buffer entries (power of two)
//  AW         4    index width, log2(DEPTH)
//  EW         8    epoch counter width
//  MAX_EPOCH  200  epoch limit; must be >= 1 and < 2**EW
// PORTS
//  clk           in   1     rising-edge clock
//  rst           in   1     asynchronous, active-low reset
//  clr           in   1     sync clear: empty the buffer and return to IDLE
//  wr_en         in   1     write one sample (IDLE only)
//  wr_x1         in   7     sample x1, signed two's complement
//  wr_x2         in   7     sample x2, signed two's complement
//  wr_t          in   2     target: 2'b01 = +1, 2'b11 = -1
//  start         in   1     begin training from epoch 0
//  next          in   1     controller consumes the current sample
//  upd           in   1     weights were updated for the current sample; sampled with next
//  x1Data        out  7     current sample x1 (registered)
//  x2Data        out  7     current sample x2 (registered)
//  tData         out  2     current sample target (registered)
//  sample_valid  out  1     data outputs hold a sample awaiting next
//  idx           out  AW    index of the current sample
//  count         out  AW+1  number of loaded samples, 0..DEPTH
//  full          out  1     count == DEPTH
//  epoch_done    out  1     one-cycle pulse at the end of each epoch
//  epoch         out  EW    number of completed epochs
//  converged     out  1     last epoch had no updates (sticky until start/clr)
//  timeout       out  1     epoch limit reached without convergence (sticky)
//  busy          out  1     state is SHOW or EVAL
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs and counters = 0.
//    Buffer contents are don't-care.
//  Priority within a cycle: clr > start > wr_en.
//    - clr in any state: IDLE, count=0, idx=0, epoch=0, all flags cleared.
//  IDLE
//    - wr_en && !full: mem[count] <= sample; count++.
//    - wr_en while full: dropped; count is unchanged.
//    - start && count>0: go to SHOW; idx=0, epoch=0, dirty=0,
//      converged=timeout=0. Any wr_en in the same cycle is dropped.
//    - start && count==0: ignored.
//  SHOW
//    - sample_valid=1; data outputs = mem[idx].
//    - On next: dirty <= dirty|upd.
//      - If idx < count-1: idx++. New data appears on the next edge and
//        sample_valid stays 1 (one transfer per next cycle).
//      - If idx == count-1: go to EVAL; sample_valid=0.
//    - wr_en and start are ignored.
//  EVAL (exactly 1 cycle)
//    - epoch_done=1; epoch++.
//    - dirty==0: go to DONE, converged=1.
//    - else if epoch+1 == MAX_EPOCH: go to DONE, timeout=1.
//    - else: go to SHOW with idx=0, dirty=0.
//  DONE
//    - sample_valid=0; data outputs hold the last sample; flags are held.
//    - start: restart as from IDLE, keeping the buffer.
//    - wr_en: ignored.
//  next while sample_valid=0 is ignored; upd without next is ignored.
//  Single-sample buffer (count=1): every next ends the epoch.
//  Reset mid-epoch: immediate return to reset values; in-flight sample is lost.
//  epoch never exceeds MAX_EPOCH; converged and timeout are never both 1.
// TESTING
//  1 Load 3 samples (x1=5,-3,7; x2=2,4,-8; t=+1,-1,+1); start; next x3 with upd=0
//    -> outputs step through the samples; epoch_done pulses once; epoch=1; converged=1.
//  2 Same load; upd=1 on sample 2 in epoch 1 only
//    -> epoch 2 replays from idx=0; converged=1 with epoch=2.
//  3 MAX_EPOCH=4; upd=1 every epoch
//    -> timeout=1, epoch=4, converged=0, four epoch_done pulses.
//  4 Write 17 samples into DEPTH=16
//    -> count=16, full=1, 17th dropped; start with count=0 -> stays IDLE.
//  5 rst=0 mid-epoch (idx=2), or clr in SHOW
//    -> next cycle: IDLE, count=0 (clr case), sample_valid=0, epoch=0.
//  6 start and wr_en same cycle in IDLE; next held high continuously
//    -> write dropped; one sample consumed per cycle; EVAL inserts one invalid cycle.

Source files
------------

// File: rtl/training_sample_feeder.sv
// Training sample buffer and epoch sequencer for the perceptron datapath.
// Presents stored samples one per 'next', tracks per-epoch updates, reports convergence/timeout.
module training_sample_feeder #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int EW        = 8,
    parameter int MAX_EPOCH = 200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [6:0]    wr_x1,
    input  logic [6:0]    wr_x2,
    input  logic [1:0]    wr_t,
    input  logic          start,
    input  logic          next,
    input  logic          upd,
    output logic [6:0]    x1Data,
    output logic [6:0]    x2Data,
    output logic [1:0]    tData,
    output logic          sample_valid,
    output logic [AW-1:0] idx,
    output logic [AW:0]   count,
    output logic          full,
    output logic          epoch_done,
    output logic [EW-1:0] epoch,
    output logic          converged,
    output logic          timeout,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, SHOW, EVAL, DONE} state_t;

    state_t state, state_next;

    logic [15:0]   mem [DEPTH];
    logic          dirty;
    logic          last;
    logic          do_write, do_begin, do_rewind, do_advance, do_consume;
    logic          set_conv, set_timeout;
    logic [AW-1:0] rd_idx;
    logic [15:0]   rd_word;

    assign last         = ({1'b0, idx} == count - (AW+1)'(1));
    assign full         = (count == (AW+1)'(DEPTH));
    assign sample_valid = (state == SHOW);
    assign busy         = (state == SHOW) || (state == EVAL);
    assign epoch_done   = (state == EVAL);

    // The output register is loaded with the word the next cycle will present.
    assign rd_idx  = do_advance ? idx + AW'(1) : '0;
    assign rd_word = mem[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next  = state;
        do_write    = 1'b0;
        do_begin    = 1'b0;
        do_rewind   = 1'b0;
        do_advance  = 1'b0;
        do_consume  = 1'b0;
        set_conv    = 1'b0;
        set_timeout = 1'b0;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && count != '0) begin
                        state_next = SHOW;
                        do_begin   = 1'b1;
                    end else if (wr_en && !full) begin
                        do_write = 1'b1;
                    end
                end
                SHOW: begin
                    if (next) begin
                        do_consume = 1'b1;
                        if (last) state_next = EVAL;
                        else      do_advance = 1'b1;
                    end
                end
                EVAL: begin
                    if (!dirty) begin
                        state_next = DONE;
                        set_conv   = 1'b1;
                    end else if (epoch == EW'(MAX_EPOCH - 1)) begin
                        state_next  = DONE;
                        set_timeout = 1'b1;
                    end else begin
                        state_next = SHOW;
                        do_rewind  = 1'b1;
                    end
                end
                DONE: begin
                    if (start && count != '0) begin
                        state_next = SHOW;
                        do_begin   = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[count[AW-1:0]] <= {wr_x1, wr_x2, wr_t};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            idx       <= '0;
            epoch     <= '0;
            dirty     <= 1'b0;
            converged <= 1'b0;
            timeout   <= 1'b0;
            x1Data    <= '0;
            x2Data    <= '0;
            tData     <= '0;
        end else if (clr) begin
            count     <= '0;
            idx       <= '0;
            epoch     <= '0;
            dirty     <= 1'b0;
            converged <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (do_write) count <= count + (AW+1)'(1);
            if (do_begin || do_rewind) begin
                idx   <= '0;
                dirty <= 1'b0;
            end
            if (do_begin) begin
                epoch     <= '0;
                converged <= 1'b0;
                timeout   <= 1'b0;
            end
            if (do_advance) idx <= idx + AW'(1);
            if (do_consume) dirty <= dirty | upd;
            if (do_begin || do_rewind || do_advance) {x1Data, x2Data, tData} <= rd_word;
            if (state == EVAL) epoch <= epoch + EW'(1);
            if (set_conv)    converged <= 1'b1;
            if (set_timeout) timeout   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_training_sample_feeder.sv
// Randomized self-checking bench for training_sample_feeder against a behavioural epoch model.
module tb_training_sample_feeder;

    localparam int M = 4;

    logic       clk = 1'b0;
    logic       rst, clr, wr_en, start, next, upd;
    logic [6:0] wr_x1, wr_x2;
    logic [1:0] wr_t;
    logic [6:0] x1Data, x2Data;
    logic [1:0] tData;
    logic       sample_valid, full, epoch_done, converged, timeout, busy;
    logic [3:0] idx;
    logic [4:0] count;
    logic [7:0] epoch;

    training_sample_feeder #(.MAX_EPOCH(M)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en),
        .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_t(wr_t),
        .start(start), .next(next), .upd(upd),
        .x1Data(x1Data), .x2Data(x2Data), .tData(tData),
        .sample_valid(sample_valid), .idx(idx), .count(count), .full(full),
        .epoch_done(epoch_done), .epoch(epoch), .converged(converged),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ep_pulses = 0;
    bit chk_en = 0;

    // Behavioural model: buffer as an array, presentation as a cursor plus phase flags.
    logic [15:0] m_buf [16];
    logic [15:0] m_data;
    int m_count, m_cur, m_epoch;
    bit m_pres, m_closing, m_fin, m_dirty, m_conv, m_to;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_count = 0; m_cur = 0; m_epoch = 0;
        m_pres = 0; m_closing = 0; m_fin = 0;
        m_dirty = 0; m_conv = 0; m_to = 0;
        m_data = '0;
    endfunction

    function automatic void model_step();
        if (clr) begin
            m_count = 0; m_cur = 0; m_epoch = 0;
            m_pres = 0; m_closing = 0; m_fin = 0;
            m_dirty = 0; m_conv = 0; m_to = 0;
        end else if (m_closing) begin
            m_closing = 0;
            m_epoch++;
            if (!m_dirty) begin
                m_conv = 1; m_fin = 1;
            end else if (m_epoch == M) begin
                m_to = 1; m_fin = 1;
            end else begin
                m_pres = 1; m_cur = 0; m_dirty = 0; m_data = m_buf[0];
            end
        end else if (m_pres) begin
            if (next) begin
                m_dirty = m_dirty | upd;
                if (m_cur == m_count - 1) begin
                    m_pres = 0; m_closing = 1;
                end else begin
                    m_cur++;
                    m_data = m_buf[m_cur];
                end
            end
        end else if (start && m_count > 0) begin
            m_pres = 1; m_fin = 0; m_cur = 0; m_epoch = 0;
            m_dirty = 0; m_conv = 0; m_to = 0;
            m_data = m_buf[0];
        end else if (!m_fin && wr_en && m_count < 16) begin
            m_buf[m_count] = {wr_x1, wr_x2, wr_t};
            m_count++;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sample_valid", 32'(sample_valid), 32'(m_pres));
            chk("busy",         32'(busy),         32'(m_pres | m_closing));
            chk("epoch_done",   32'(epoch_done),   32'(m_closing));
            chk("idx",          32'(idx),          32'(m_cur));
            chk("count",        32'(count),        32'(m_count));
            chk("full",         32'(full),         32'(m_count == 16));
            chk("epoch",        32'(epoch),        32'(m_epoch));
            chk("converged",    32'(converged),    32'(m_conv));
            chk("timeout",      32'(timeout),      32'(m_to));
            chk("x1Data",       32'(x1Data),       32'(m_data[15:9]));
            chk("x2Data",       32'(x2Data),       32'(m_data[8:2]));
            chk("tData",        32'(tData),        32'(m_data[1:0]));
            if (m_conv && m_to) begin
                checks++; errors++;
                $display("FAIL model_flags at %0t: converged and timeout both set", $time);
            end
            if (epoch_done) ep_pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic write_sample(input logic [6:0] a, input logic [6:0] b, input logic [1:0] t);
        wr_en = 1; wr_x1 = a; wr_x2 = b; wr_t = t;
        tick();
        wr_en = 0;
    endtask

    task automatic do_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic do_next(input logic u);
        next = 1; upd = u; tick(); next = 0; upd = 0;
    endtask

    task automatic do_clr();
        clr = 1; tick(); clr = 0;
    endtask

    task automatic load3();
        write_sample(7'd5,  7'd2,  2'b01);
        write_sample(7'h7D, 7'd4,  2'b11);
        write_sample(7'd7,  7'h78, 2'b01);
    endtask

    task automatic hard_reset();
        #2 rst = 0;
        model_reset();
        @(negedge clk);
        #1;
        #1 rst = 1;
    endtask

    initial begin
        rst = 0; clr = 0; wr_en = 0; start = 0; next = 0; upd = 0;
        wr_x1 = '0; wr_x2 = '0; wr_t = '0;
        model_reset();
        chk_en = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        #1 rst = 1;

        // Clean single epoch
        load3();
        ep_pulses = 0;
        do_start();
        chk("t1_first_x1", 32'(x1Data), 32'd5);
        chk("t1_first_t",  32'(tData),  32'd1);
        do_next(0);
        chk("t1_second_x1", 32'(x1Data), 32'h7D);
        chk("t1_second_x2", 32'(x2Data), 32'd4);
        do_next(0);
        chk("t1_third_x2", 32'(x2Data), 32'h78);
        do_next(0);
        chk("t1_eval_pulse", 32'(epoch_done), 32'd1);
        tick();
        chk("t1_epoch", 32'(epoch), 32'd1);
        chk("t1_conv",  32'(converged), 32'd1);
        chk("t1_pulses", 32'(ep_pulses), 32'd1);

        // One dirty epoch then a clean replay
        do_start();
        do_next(0); do_next(1); do_next(0);
        tick();
        chk("t2_replay_idx", 32'(idx), 32'd0);
        chk("t2_replay_x1",  32'(x1Data), 32'd5);
        do_next(0); do_next(0); do_next(0);
        tick();
        chk("t2_epoch", 32'(epoch), 32'd2);
        chk("t2_conv",  32'(converged), 32'd1);

        // Always dirty -> timeout at M epochs
        ep_pulses = 0;
        do_start();
        repeat (M) begin
            do_next(1); do_next(1); do_next(1);
            tick();
        end
        chk("t3_timeout", 32'(timeout), 32'd1);
        chk("t3_epoch",   32'(epoch), 32'(M));
        chk("t3_conv",    32'(converged), 32'd0);
        chk("t3_pulses",  32'(ep_pulses), 32'(M));

        // Overfill and empty start
        do_clr();
        for (int i = 0; i < 17; i++)
            write_sample(7'($urandom), 7'($urandom), ($urandom % 2) ? 2'b11 : 2'b01);
        chk("t4_count", 32'(count), 32'd16);
        chk("t4_full",  32'(full), 32'd1);
        do_start();
        repeat (16) do_next(0);
        tick();
        do_clr();
        do_start();
        chk("t4_empty_start", 32'(sample_valid), 32'd0);

        // Reset mid-epoch, clr in SHOW
        load3();
        do_start();
        do_next(1); do_next(0);
        chk("t5_idx_before", 32'(idx), 32'd2);
        hard_reset();
        chk("t5_rst_valid", 32'(sample_valid), 32'd0);
        chk("t5_rst_epoch", 32'(epoch), 32'd0);
        load3();
        do_start();
        do_next(0);
        do_clr();
        chk("t5_clr_count", 32'(count), 32'd0);
        chk("t5_clr_valid", 32'(sample_valid), 32'd0);

        // start+wr_en together; next held continuously
        load3();
        start = 1; wr_en = 1; wr_x1 = 7'd9; wr_x2 = 7'd9; wr_t = 2'b01;
        tick();
        start = 0; wr_en = 0;
        chk("t6_count", 32'(count), 32'd3);
        next = 1;
        tick(); tick(); tick();
        chk("t6_eval_gap", 32'(sample_valid), 32'd0);
        tick(); tick();
        next = 0;
        chk("t6_conv", 32'(converged), 32'd1);

        // Randomized traffic
        do_clr();
        for (int i = 0; i < 2500; i++) begin
            clr   = ($urandom_range(0, 99) < 1);
            start = ($urandom_range(0, 99) < 4);
            wr_en = !start && ($urandom_range(0, 99) < 35);
            next  = ($urandom_range(0, 99) < 60);
            upd   = ($urandom_range(0, 99) < 25);
            wr_x1 = 7'($urandom); wr_x2 = 7'($urandom);
            wr_t  = ($urandom % 2) ? 2'b11 : 2'b01;
            tick();
        end
        clr = 0; start = 0; wr_en = 0; next = 0; upd = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
